// File: rtl/cpu_pkg.sv
// Shared constants, opcode encodings and the default program image for the SAP-style CPU.
package cpu_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned IMM_W  = 4;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] rom_addr_t;

    typedef enum logic [3:0] {
        NOP = 4'b0000,
        LDI = 4'b0101,
        OUT = 4'b1110,
        HLT = 4'b1111
    } opcode_e;

    // Boot program: LDI 7, OUT, HLT, then NOP to the end of the table.
    function automatic word_t default_rom_word(rom_addr_t addr);
        word_t w;
        case (addr)
            rom_addr_t'(0): w = {LDI, 4'h7};
            rom_addr_t'(1): w = {OUT, 4'h0};
            rom_addr_t'(2): w = {HLT, 4'h0};
            default:        w = {NOP, 4'h0};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bus_reg_rom_if.sv
// Control/status bundle between the CPU sequencer (master) and bus_reg_rom (slave).
interface bus_reg_rom_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = cpu_pkg::WIDTH,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);

    logic              i_reg_load;
    logic              i_reg_enable;
    logic              i_reg_only_lower;
    logic              i_rom_enable;
    logic [ADDR_W-1:0] i_rom_addr;
    logic              i_rom_we;
    logic [WIDTH-1:0]  o_reg_q;

    modport master (
        output i_reg_load, i_reg_enable, i_reg_only_lower,
        output i_rom_enable, i_rom_addr, i_rom_we,
        input  o_reg_q
    );

    modport slave (
        input  i_reg_load, i_reg_enable, i_reg_only_lower,
        input  i_rom_enable, i_rom_addr, i_rom_we,
        output o_reg_q
    );

endinterface

// File: rtl/bus_register.sv
// Loadable bus register; presents its full value or just the immediate field for the bus.
module bus_register
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = cpu_pkg::WIDTH,
    parameter int unsigned IMM_W = cpu_pkg::IMM_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic             i_only_lower,
    input  logic [WIDTH-1:0] i_bus,
    output logic             o_drive_en,
    output logic [WIDTH-1:0] o_drive,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q <= '0;
        end else if (i_load) begin
            q <= i_bus;
        end
    end

    always_comb begin
        o_drive_en = i_enable;
        o_drive    = q;
        if (i_only_lower) begin
            o_drive = {{(WIDTH-IMM_W){1'b0}}, q[IMM_W-1:0]};
        end
    end

    assign o_q = q;

endmodule

// File: rtl/bus_reg_rom.sv
// General register plus 16x8 program ROM sharing one tri-state bus.
// Define PROG_WRITE_EN to make the ROM writable from the bus.
module bus_reg_rom
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = cpu_pkg::WIDTH,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned IMM_W  = cpu_pkg::IMM_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    inout  wire  [WIDTH-1:0] io_bus,
    bus_reg_rom_if.slave     bus_if
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic             reg_drive_en;
    logic [WIDTH-1:0] reg_drive;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] rom_data;

    // ROM has priority: the register is gated off whenever the ROM drives.
    bus_register #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_bus_register (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (bus_if.i_reg_load),
        .i_enable     (bus_if.i_reg_enable & ~bus_if.i_rom_enable),
        .i_only_lower (bus_if.i_reg_only_lower),
        .i_bus        (io_bus),
        .o_drive_en   (reg_drive_en),
        .o_drive      (reg_drive),
        .o_q          (reg_q)
    );

    assign bus_if.o_reg_q = reg_q;

`ifdef PROG_WRITE_EN
    typedef logic [WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t boot_image();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = WIDTH'(default_rom_word(rom_addr_t'(i)));
        end
        return m;
    endfunction

    // Power-up contents come from the declaration; reset deliberately leaves mem alone.
    mem_t mem = boot_image();

    always_ff @(posedge i_clk) begin
        if (bus_if.i_rom_we) begin
            mem[bus_if.i_rom_addr] <= io_bus;
        end
    end

    assign rom_data = mem[bus_if.i_rom_addr];
`else
    logic unused_rom_we;
    assign unused_rom_we = bus_if.i_rom_we;

    assign rom_data = WIDTH'(default_rom_word(rom_addr_t'(bus_if.i_rom_addr)));
`endif

    assign io_bus = bus_if.i_rom_enable ? rom_data :
                    reg_drive_en        ? reg_drive : 'z;

endmodule

// File: tb/tb_bus_reg_rom.sv
// Directed self-checking bench for bus_reg_rom (register, ROM reads, priority, optional write).
module tb_bus_reg_rom;
    import cpu_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] tb_drv;
    logic       tb_oe;
    wire  [7:0] bus;
    int         n_checks;
    int         n_pass;

    bus_reg_rom_if #(.WIDTH(8), .ADDR_W(4)) bif ();

    bus_reg_rom #(
        .WIDTH  (8),
        .ADDR_W (4),
        .IMM_W  (4)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus),
        .bus_if (bif)
    );

    assign bus = tb_oe ? tb_drv : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        bif.i_reg_load       = 1'b0;
        bif.i_reg_enable     = 1'b0;
        bif.i_reg_only_lower = 1'b0;
        bif.i_rom_enable     = 1'b0;
        bif.i_rom_addr       = 4'd0;
        bif.i_rom_we         = 1'b0;
        tb_oe                = 1'b0;
        tb_drv               = 8'h00;
    endtask

    logic [7:0] rom_exp [5];
    logic [3:0] rom_adr [5];
    logic [7:0] wr_exp;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle();
        rom_adr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
        rom_exp = '{8'h57, 8'hE0, 8'hF0, 8'h00, 8'h00};
`ifdef PROG_WRITE_EN
        wr_exp = 8'h3C;
`else
        wr_exp = 8'h00;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_q", bif.o_reg_q, 8'h00);

        // No enables: bench-driven values must come back untouched.
        tb_oe = 1'b1; tb_drv = 8'h00; #1;
        check("undriven_00", bus, 8'h00);
        tb_drv = 8'h5A; #1;
        check("undriven_5a", bus, 8'h5A);
        tb_oe = 1'b0;

        bif.i_rom_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bif.i_rom_addr = rom_adr[i];
            #1;
            check($sformatf("rom_rd_%0d", rom_adr[i]), bus, rom_exp[i]);
        end

        // LDI fetch: load ROM word 0 into the register.
        @(negedge clk);
        bif.i_rom_addr = 4'd0;
        bif.i_reg_load = 1'b1;
        @(posedge clk); #1;
        check("load_rom_q", bif.o_reg_q, 8'h57);
        @(negedge clk);
        idle();
        bif.i_reg_enable     = 1'b1;
        bif.i_reg_only_lower = 1'b1;
        #1;
        check("imm_drive", bus, 8'h07);
        bif.i_reg_only_lower = 1'b0;
        #1;
        check("full_drive", bus, 8'h57);

        @(negedge clk);
        idle();
        tb_oe = 1'b1; tb_drv = 8'hA5;
        bif.i_reg_load = 1'b1;
        @(posedge clk); #1;
        check("load_ext_q", bif.o_reg_q, 8'hA5);
        @(negedge clk);
        idle();
        bif.i_reg_enable = 1'b1;
        #1;
        check("reg_drive_a5", bus, 8'hA5);
        bif.i_rom_enable = 1'b1;
        bif.i_rom_addr   = 4'd1;
        #1;
        check("rom_wins_e0", bus, 8'hE0);
        bif.i_rom_addr = 4'd3;
        #1;
        check("rom_wins_00", bus, 8'h00);

        // Load while driving in immediate mode clears the upper nibble.
        @(negedge clk);
        idle();
        bif.i_reg_enable     = 1'b1;
        bif.i_reg_only_lower = 1'b1;
        bif.i_reg_load       = 1'b1;
        @(posedge clk); #1;
        check("self_reload_q", bif.o_reg_q, 8'h05);
        @(negedge clk);
        idle();
        check("hold_q", bif.o_reg_q, 8'h05);

        // Asynchronous reset mid-cycle, well away from any posedge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", bif.o_reg_q, 8'h00);
        #1 rst = 1'b0;

        @(negedge clk);
        tb_oe = 1'b1; tb_drv = 8'h3C;
        bif.i_rom_we   = 1'b1;
        bif.i_rom_addr = 4'd4;
        @(posedge clk); #1;
        idle();
        bif.i_rom_enable = 1'b1;
        bif.i_rom_addr   = 4'd4;
        #1;
        check("rom_wr_rd", bus, wr_exp);
        rst = 1'b1; #1; rst = 1'b0; #1;
        check("rom_after_rst", bus, wr_exp);
        bif.i_rom_addr = 4'd0;
        #1;
        check("rom0_intact", bus, 8'h57);

        @(negedge clk);
        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
